// File: rtl/nco_pkg.sv
// Shared NCO types and constants: sweep FSM states and the common phase-increment width.
package nco_pkg;

    localparam int unsigned NCO_PHASE_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        LAST  = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Control/status bundle between a sweep requester (master) and nco_sweep_ctrl (slave).
interface nco_sweep_ctrl_if
    import nco_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = NCO_PHASE_WIDTH,
    parameter int unsigned DWELL_WIDTH = 16
) ();

    logic                   start;
    logic                   abort;
    logic [PHASE_WIDTH-1:0] f_start;
    logic [PHASE_WIDTH-1:0] f_stop;
    logic [PHASE_WIDTH-1:0] f_step;
    logic [DWELL_WIDTH-1:0] dwell;
    logic [PHASE_WIDTH-1:0] phase_inc;
    logic                   busy;
    logic                   sweep_done;

    modport master (
        output start, abort, f_start, f_stop, f_step, dwell,
        input  phase_inc, busy, sweep_done
    );

    modport slave (
        input  start, abort, f_start, f_stop, f_step, dwell,
        output phase_inc, busy, sweep_done
    );

endinterface

// File: rtl/nco_sweep_ctrl_dwell_timer.sv
// Loadable down-counter timing how long each sweep frequency is held.
module dwell_timer #(
    parameter int unsigned DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic [DWELL_WIDTH-1:0] i_load_val,
    input  logic                   i_en,
    output logic                   o_expire
);

    localparam logic [DWELL_WIDTH-1:0] ONE = DWELL_WIDTH'(1);

    logic [DWELL_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - ONE;
        end
    end

    assign o_expire = (r_count == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Linear frequency-sweep controller driving the nco phase increment.
// Optional triangular (ping-pong) repetition enabled by defining NCO_SWEEP_PINGPONG_EN.
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = NCO_PHASE_WIDTH,
    parameter int unsigned DWELL_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    nco_sweep_ctrl_if.slave    bus
);

    sweep_state_e           r_state, w_state;
    logic [PHASE_WIDTH-1:0] r_phase_inc, w_phase_inc;
    logic                   r_busy, w_busy;
    logic                   r_done, w_done;
    logic [PHASE_WIDTH-1:0] r_f_stop, w_f_stop;
    logic [PHASE_WIDTH-1:0] r_f_step, w_f_step;
    logic [DWELL_WIDTH-1:0] r_dwell, w_dwell;
    logic                   r_up, w_up;
`ifdef NCO_SWEEP_PINGPONG_EN
    logic [PHASE_WIDTH-1:0] r_f_start, w_f_start;
`endif

    logic                   w_tmr_load;
    logic [DWELL_WIDTH-1:0] w_tmr_val;
    logic                   w_tmr_en;
    logic                   w_tmr_expire;

    logic [PHASE_WIDTH:0]   w_sum;
    logic [PHASE_WIDTH:0]   w_diff;
    logic                   w_reach;
    logic [PHASE_WIDTH-1:0] w_next_val;

    dwell_timer #(.DWELL_WIDTH(DWELL_WIDTH)) u_dwell_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_expire   (w_tmr_expire)
    );

    // One extra bit exposes carry-out (up) and borrow (down) so a step past either end clamps.
    assign w_sum      = {1'b0, r_phase_inc} + {1'b0, r_f_step};
    assign w_diff     = {1'b0, r_phase_inc} - {1'b0, r_f_step};
    assign w_reach    = r_up ? (w_sum >= {1'b0, r_f_stop})
                             : (w_diff[PHASE_WIDTH] || (w_diff[PHASE_WIDTH-1:0] <= r_f_stop));
    assign w_next_val = r_up ? w_sum[PHASE_WIDTH-1:0] : w_diff[PHASE_WIDTH-1:0];

    always_comb begin
        w_state     = r_state;
        w_phase_inc = r_phase_inc;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_f_stop    = r_f_stop;
        w_f_step    = r_f_step;
        w_dwell     = r_dwell;
        w_up        = r_up;
`ifdef NCO_SWEEP_PINGPONG_EN
        w_f_start   = r_f_start;
`endif
        w_tmr_load  = 1'b0;
        w_tmr_val   = r_dwell;
        w_tmr_en    = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_f_stop    = bus.f_stop;
                    w_f_step    = bus.f_step;
                    w_dwell     = bus.dwell;
                    w_up        = (bus.f_stop >= bus.f_start);
`ifdef NCO_SWEEP_PINGPONG_EN
                    w_f_start   = bus.f_start;
`endif
                    w_phase_inc = bus.f_start;
                    w_busy      = 1'b1;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = bus.dwell;
                    w_state     = ((bus.f_start == bus.f_stop) || (bus.f_step == '0)) ? LAST : SWEEP;
                end
            end

            SWEEP: begin
                if (bus.abort) begin
                    w_state = IDLE;
                    w_busy  = 1'b0;
                end else if (w_tmr_expire) begin
                    w_tmr_load = 1'b1;
                    if (w_reach) begin
                        w_phase_inc = r_f_stop;
                        w_state     = LAST;
                    end else begin
                        w_phase_inc = w_next_val;
                    end
                end else begin
                    w_tmr_en = 1'b1;
                end
            end

            LAST: begin
                if (bus.abort) begin
                    w_state = IDLE;
                    w_busy  = 1'b0;
                end else if (w_tmr_expire) begin
                    // A zero-step sweep reaches LAST still at f_start; settle on f_stop at the end.
                    w_phase_inc = r_f_stop;
                    w_done      = 1'b1;
`ifdef NCO_SWEEP_PINGPONG_EN
                    w_f_start   = r_f_stop;
                    w_f_stop    = r_f_start;
                    w_up        = ~r_up;
                    w_tmr_load  = 1'b1;
                    w_state     = SWEEP;
`else
                    w_busy      = 1'b0;
                    w_state     = IDLE;
`endif
                end else begin
                    w_tmr_en = 1'b1;
                end
            end

            default: begin
                w_state = IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_phase_inc <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_f_stop    <= '0;
            r_f_step    <= '0;
            r_dwell     <= '0;
            r_up        <= 1'b0;
`ifdef NCO_SWEEP_PINGPONG_EN
            r_f_start   <= '0;
`endif
        end else begin
            r_state     <= w_state;
            r_phase_inc <= w_phase_inc;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_f_stop    <= w_f_stop;
            r_f_step    <= w_f_step;
            r_dwell     <= w_dwell;
            r_up        <= w_up;
`ifdef NCO_SWEEP_PINGPONG_EN
            r_f_start   <= w_f_start;
`endif
        end
    end

    assign bus.phase_inc  = r_phase_inc;
    assign bus.busy       = r_busy;
    assign bus.sweep_done = r_done;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl (single-sweep build): queue-based reference model plus directed literals.
module tb_nco_sweep_ctrl;

    localparam int unsigned PW = 32;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    nco_sweep_ctrl_if #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) bus ();

    nco_sweep_ctrl #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [PW-1:0] ph;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Whole expected output trace of one sweep: each frequency held dwell+1 cycles, then a done cycle.
    function automatic void build(input logic [PW-1:0] fs, input logic [PW-1:0] fe,
                                  input logic [PW-1:0] st, input logic [DW-1:0] dw);
        logic [PW-1:0] fq[$];
        longint        c, nx, stop;
        bit            up;
        exp_t          e;
        up   = (fe >= fs);
        stop = {32'h0, fe};
        fq.push_back(fs);
        if (fs != fe && st != '0) begin
            c = {32'h0, fs};
            forever begin
                nx = up ? (c + {32'h0, st}) : (c - {32'h0, st});
                if (up ? (nx >= stop) : (nx <= stop)) begin
                    fq.push_back(fe);
                    break;
                end
                fq.push_back(nx[PW-1:0]);
                c = nx;
            end
        end
        foreach (fq[i]) begin
            for (int unsigned k = 0; k <= dw; k++) begin
                e.ph = fq[i]; e.busy = 1'b1; e.done = 1'b0;
                exp_q.push_back(e);
            end
        end
        e.ph = fe; e.busy = 1'b0; e.done = 1'b1;
        exp_q.push_back(e);
    endfunction

    initial begin
        cur = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
                cur = '0;
            end else if (cur.busy) begin
                if (bus.abort) begin
                    exp_q.delete();
                    cur.busy = 1'b0;
                    cur.done = 1'b0;
                end else if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                end
            end else begin
                cur.done = 1'b0;
                if (bus.start && !bus.abort) begin
                    build(bus.f_start, bus.f_stop, bus.f_step, bus.dwell);
                    cur = exp_q.pop_front();
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            n_vec++;
            if (bus.phase_inc !== cur.ph || bus.busy !== cur.busy || bus.sweep_done !== cur.done) begin
                n_bad++;
                $display("FAIL cycle @%0t: phase_inc=%h busy=%b sweep_done=%b, expected %h %b %b",
                         $time, bus.phase_inc, bus.busy, bus.sweep_done, cur.ph, cur.busy, cur.done);
            end
        end
    end

    task automatic lit_check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sweep(input logic [PW-1:0] fs, input logic [PW-1:0] fe,
                               input logic [PW-1:0] st, input logic [DW-1:0] dw);
        bus.f_start = fs;
        bus.f_stop  = fe;
        bus.f_step  = st;
        bus.dwell   = dw;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.f_start = $urandom;
        bus.f_stop  = $urandom;
        bus.f_step  = $urandom;
        bus.dwell   = DW'($urandom);
    endtask

    task automatic wait_idle(input int unsigned budget);
        for (int unsigned k = 0; k < budget; k++) begin
            if (!bus.busy) return;
            tick();
        end
        n_vec++;
        n_bad++;
        $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", budget);
    endtask

    task automatic run_lit(input string name, input logic [PW-1:0] fs, input logic [PW-1:0] fe,
                           input logic [PW-1:0] st, input logic [DW-1:0] dw,
                           input logic [PW-1:0] lits[12], input int unsigned n);
        start_sweep(fs, fe, st, dw);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            lit_check({name, "_phase"}, bus.phase_inc, lits[i]);
            lit_check({name, "_model"}, cur.ph, lits[i]);
        end
        @(negedge clk);
        lit_check({name, "_done"}, {31'h0, bus.sweep_done}, 32'd1);
        lit_check({name, "_busy"}, {31'h0, bus.busy}, 32'd0);
        lit_check({name, "_final"}, bus.phase_inc, fe);
    endtask

    logic [PW-1:0] lits[12];
    logic [PW-1:0] fs, fe, st;
    logic [DW-1:0] dw;

    initial begin
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.f_start = '0;
        bus.f_stop  = '0;
        bus.f_step  = '0;
        bus.dwell   = '0;
        rst         = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        lit_check("reset_phase", bus.phase_inc, 32'd0);
        lit_check("reset_busy", {31'h0, bus.busy}, 32'd0);

        lits = '{100, 100, 100, 110, 110, 110, 120, 120, 120, 130, 130, 130};
        run_lit("up", 100, 130, 10, 2, lits, 12);
        tick(); tick();
        @(negedge clk);
        lit_check("idle_hold", bus.phase_inc, 32'd130);

        lits = '{100, 90, 80, 75, 0, 0, 0, 0, 0, 0, 0, 0};
        run_lit("down_clamp", 100, 75, 10, 0, lits, 4);

        lits = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_lit("top_clamp", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, lits, 2);

        lits = '{50, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_lit("step0", 50, 80, 0, 1, lits, 2);

        lits = '{60, 60, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_lit("equal", 60, 60, 5, 1, lits, 2);

        // abort once phase_inc reaches 110
        start_sweep(100, 130, 10, 2);
        for (int unsigned k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.phase_inc == 32'd110) break;
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        lit_check("abort_busy", {31'h0, bus.busy}, 32'd0);
        lit_check("abort_phase", bus.phase_inc, 32'd110);
        lit_check("abort_nodone", {31'h0, bus.sweep_done}, 32'd0);

        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.f_start = 500; bus.f_stop = 600; bus.f_step = 10; bus.dwell = 0;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        lit_check("start_abort_busy", {31'h0, bus.busy}, 32'd0);
        lit_check("start_abort_phase", bus.phase_inc, 32'd110);

        start_sweep(0, 50, 5, 1);
        repeat (3) tick();
        bus.f_start = 900; bus.f_stop = 950; bus.f_step = 1; bus.dwell = 7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_idle(200);

        start_sweep(200, 100, 7, 1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        lit_check("rst_phase", bus.phase_inc, 32'd0);
        lit_check("rst_busy", {31'h0, bus.busy}, 32'd0);
        lits = '{100, 100, 100, 110, 110, 110, 120, 120, 120, 130, 130, 130};
        run_lit("after_rst", 100, 130, 10, 2, lits, 12);

        for (int unsigned t = 0; t < 40; t++) begin
            if (t % 8 == 0) begin
                fs = 32'hFFFF_FF00 + $urandom_range(0, 255);
                fe = 32'hFFFF_FF00 + $urandom_range(0, 255);
            end else begin
                fs = $urandom_range(0, 1000);
                fe = $urandom_range(0, 1000);
            end
            if (t % 5 == 0)       st = 32'h8000_0000 | $urandom;
            else if (t % 7 == 3)  st = '0;
            else                  st = $urandom_range(20, 150);
            dw = DW'($urandom_range(0, 3));
            tick();
            start_sweep(fs, fe, st, dw);
            for (int unsigned k = 0; k < 1000; k++) begin
                if (!bus.busy) break;
                bus.abort = ($urandom_range(0, 59) == 0);
                bus.start = ($urandom_range(0, 29) == 0);
                if (bus.start) begin
                    bus.f_start = $urandom_range(0, 1000);
                    bus.f_stop  = $urandom_range(0, 1000);
                    bus.f_step  = $urandom_range(1, 50);
                end
                tick();
                bus.abort = 1'b0;
                bus.start = 1'b0;
            end
            wait_idle(10);
        end

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
